// File: rtl/alu_pkg.sv
// Shared definitions for the lab ALU datapath: entry-sequencer states,
// ALU opcodes and data width.
package alu_pkg;

   localparam int W = 4;

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_SHOW = 3'd4
   } state_t;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_NOT = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_OR  = 3'd4;
   localparam logic [2:0] OP_XOR = 3'd5;
   localparam logic [2:0] OP_LT  = 3'd6;
   localparam logic [2:0] OP_EQ  = 3'd7;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level counter and a
// registered rising-edge pulse. Releases never produce a pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic press_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             btn_s_q;
   logic             lvl_q;
   logic             lvl_prev_q;
   logic             press_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         btn_s_q    <= 1'b0;
         lvl_q      <= 1'b0;
         lvl_prev_q <= 1'b0;
         press_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         sync1_q    <= btn_i;
         btn_s_q    <= sync1_q;
         lvl_prev_q <= lvl_q;
         press_q    <= lvl_q & ~lvl_prev_q;
         // Any cycle where the synchronized input agrees with the accepted
         // level restarts the stability window, so short bounces are absorbed.
         if (btn_s_q == lvl_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            lvl_q <= btn_s_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/alu_input_seq.sv
// Operand-entry sequencer for the board-lab ALU: one debounced enter button
// steps through A -> B -> OP -> EXEC -> SHOW and captures the ALU result.
module alu_input_seq
   import alu_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         btn_i,
   input  logic [W-1:0] sw_i,
   input  logic [2:0]   sw_op_i,
   output logic [W-1:0] a_o,
   output logic [W-1:0] b_o,
   output logic [2:0]   ctrl_o,
   input  logic [W-1:0] res_i,
   input  logic         car_i,
   input  logic         of_i,
   output logic [W-1:0] res_q_o,
   output logic         car_q_o,
   output logic         of_q_o,
   output logic         valid_o,
   output logic [2:0]   state_o
);

   logic         press;
   state_t       state_q;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;
   logic [2:0]   ctrl_q;
   logic [W-1:0] res_q;
   logic         car_q;
   logic         of_q;
   logic         valid_q;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn_i),
      .press_o(press)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         ctrl_q  <= '0;
         res_q   <= '0;
         car_q   <= 1'b0;
         of_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_A: if (press) begin
               a_q     <= sw_i;
               state_q <= S_B;
            end
            S_B: if (press) begin
               b_q     <= sw_i;
               state_q <= S_OP;
            end
            S_OP: if (press) begin
               ctrl_q  <= sw_op_i;
               state_q <= S_EXEC;
            end
            // The ALU has had the new operands for a full cycle here; press
            // is deliberately ignored so SHOW is never skipped.
            S_EXEC: begin
               res_q   <= res_i;
               car_q   <= car_i;
               of_q    <= of_i;
               valid_q <= 1'b1;
               state_q <= S_SHOW;
            end
            S_SHOW: if (press) begin
               valid_q <= 1'b0;
               state_q <= S_A;
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= S_A;
            end
         endcase
      end
   end

   assign a_o     = a_q;
   assign b_o     = b_q;
   assign ctrl_o  = ctrl_q;
   assign res_q_o = res_q;
   assign car_q_o = car_q;
   assign of_q_o  = of_q;
   assign valid_o = valid_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_alu_input_seq.sv
// Directed bench for alu_input_seq with a behavioural 4-bit ALU closing the
// a/b/ctrl -> res/car/of loop.
module tb_alu_input_seq;
   import alu_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         btn = 1'b0;
   logic [3:0]   sw_i = '0;
   logic [2:0]   sw_op_i = '0;
   logic [3:0]   a_o, b_o, res_q_o;
   logic [2:0]   ctrl_o, state_o;
   logic         car_q_o, of_q_o, valid_o;
   logic [3:0]   alu_res;
   logic         alu_car, alu_of;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   always #5 clk = ~clk;

   alu_input_seq #(.DEBOUNCE_CYCLES(16), .CNT_W(20)) dut (
      .clk(clk), .rst(rst), .btn_i(btn), .sw_i(sw_i), .sw_op_i(sw_op_i),
      .a_o(a_o), .b_o(b_o), .ctrl_o(ctrl_o),
      .res_i(alu_res), .car_i(alu_car), .of_i(alu_of),
      .res_q_o(res_q_o), .car_q_o(car_q_o), .of_q_o(of_q_o),
      .valid_o(valid_o), .state_o(state_o)
   );

   // Lab ALU: carry is carry-out for ADD and borrow for SUB/EQ; EQ is a
   // subtraction whose zero result indicates equality.
   always_comb begin
      alu_res = '0;
      alu_car = 1'b0;
      alu_of  = 1'b0;
      case (ctrl_o)
         OP_ADD: begin
            {alu_car, alu_res} = {1'b0, a_o} + {1'b0, b_o};
            alu_of = (a_o[3] == b_o[3]) && (alu_res[3] != a_o[3]);
         end
         OP_SUB, OP_EQ: begin
            {alu_car, alu_res} = {1'b0, a_o} - {1'b0, b_o};
            alu_of = (a_o[3] != b_o[3]) && (alu_res[3] != a_o[3]);
         end
         OP_NOT: alu_res = ~a_o;
         OP_AND: alu_res = a_o & b_o;
         OP_OR:  alu_res = a_o | b_o;
         OP_XOR: alu_res = a_o ^ b_o;
         OP_LT:  alu_res = {3'b000, ($signed(a_o) < $signed(b_o))};
         default: alu_res = '0;
      endcase
   end

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
      logic [3:0] res;
      logic       car;
      logic       of;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".a"}, a_o, 0);
      check({tag, ".b"}, b_o, 0);
      check({tag, ".ctrl"}, ctrl_o, 0);
      check({tag, ".res"}, res_q_o, 0);
      check({tag, ".car"}, car_q_o, 0);
      check({tag, ".of"}, of_q_o, 0);
      check({tag, ".valid"}, valid_o, 0);
      check({tag, ".state"}, state_o, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      btn = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Hold long enough for a press, then release long enough to settle.
   task automatic press_btn(input logic [3:0] sw, input logic [2:0] op);
      @(negedge clk);
      btn = 1'b1;
      sw_i = sw;
      sw_op_i = op;
      repeat (24) @(negedge clk);
      btn = 1'b0;
      repeat (22) @(negedge clk);
   endtask

   // Switches change every cycle; the latched value is the one present at
   // cycle 19 after the button rises.
   task automatic churn_press(input int base);
      @(negedge clk);
      btn = 1'b1;
      for (int i = 0; i < 24; i++) begin
         sw_i    = 4'(base + i);
         sw_op_i = 3'(base + i);
         @(negedge clk);
      end
      btn = 1'b0;
      for (int i = 0; i < 22; i++) begin
         sw_i    = 4'(base + 100 + i);
         sw_op_i = 3'(base + 100 + i);
         @(negedge clk);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int press_at;
      int press_n;

      vecs[0] = '{a: 4'd7,  b: 4'd1,  op: OP_ADD, res: 4'b1000, car: 1'b0, of: 1'b1};
      vecs[1] = '{a: 4'd4,  b: 4'd4,  op: OP_EQ,  res: 4'b0000, car: 1'b0, of: 1'b0};
      vecs[2] = '{a: 4'd3,  b: 4'd5,  op: OP_SUB, res: 4'b1110, car: 1'b1, of: 1'b0};
      vecs[3] = '{a: 4'hC,  b: 4'hA,  op: OP_AND, res: 4'b1000, car: 1'b0, of: 1'b0};
      vecs[4] = '{a: 4'hF,  b: 4'h1,  op: OP_ADD, res: 4'b0000, car: 1'b1, of: 1'b0};

      // Reset state and press latency.
      do_reset();
      check_all_zero("reset");
      @(negedge clk);
      btn = 1'b1;
      press_at = -1;
      press_n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (dut.u_deb.press_o) begin
            press_n++;
            if (press_at < 0) press_at = i;
         end
      end
      check("press_latency", press_at, 19);
      check("press_count_held", press_n, 1);
      btn = 1'b0;
      press_n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dut.u_deb.press_o) press_n++;
      end
      check("press_count_release", press_n, 0);
      check("state_after_one_press", state_o, S_B);

      // Bounces shorter than the debounce window.
      do_reset();
      press_n = 0;
      for (int i = 0; i < 60; i++) begin
         if (i % 3 == 0) btn = ~btn;
         @(negedge clk);
         if (dut.u_deb.press_o) press_n++;
      end
      btn = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (dut.u_deb.press_o) press_n++;
      end
      check("bounce_presses", press_n, 0);
      check("bounce_state", state_o, S_A);
      btn = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (dut.u_deb.press_o) press_n++;
      end
      btn = 1'b0;
      repeat (22) @(negedge clk);
      check("bounce_then_hold_presses", press_n, 1);
      check("bounce_then_hold_state", state_o, S_B);

      // Result latency, cycle by cycle.
      do_reset();
      press_btn(4'd7, 3'd0);
      press_btn(4'd1, 3'd0);
      @(negedge clk);
      btn = 1'b1;
      sw_op_i = OP_ADD;
      repeat (19) @(negedge clk);
      check("lat.c19_state", state_o, S_OP);
      @(negedge clk);
      check("lat.c20_state", state_o, S_EXEC);
      check("lat.c20_valid", valid_o, 0);
      check("lat.c20_ctrl", ctrl_o, OP_ADD);
      @(negedge clk);
      check("lat.c21_state", state_o, S_SHOW);
      check("lat.c21_valid", valid_o, 1);
      check("lat.c21_res", res_q_o, 4'b1000);
      btn = 1'b0;
      repeat (22) @(negedge clk);
      press_btn(4'd0, 3'd0);
      check("lat.back_to_A", state_o, S_A);

      // Table-driven full entries.
      for (int v = 0; v < 5; v++) begin
         press_btn(vecs[v].a, 3'd0);
         press_btn(vecs[v].b, 3'd0);
         press_btn(4'd0, vecs[v].op);
         check($sformatf("v%0d.a", v), a_o, vecs[v].a);
         check($sformatf("v%0d.b", v), b_o, vecs[v].b);
         check($sformatf("v%0d.ctrl", v), ctrl_o, vecs[v].op);
         check($sformatf("v%0d.res", v), res_q_o, vecs[v].res);
         check($sformatf("v%0d.car", v), car_q_o, vecs[v].car);
         check($sformatf("v%0d.of", v), of_q_o, vecs[v].of);
         check($sformatf("v%0d.valid", v), valid_o, 1);
         check($sformatf("v%0d.state", v), state_o, S_SHOW);
         press_btn(4'hF, 3'd7);
         check($sformatf("v%0d.ack_state", v), state_o, S_A);
         check($sformatf("v%0d.ack_valid", v), valid_o, 0);
         check($sformatf("v%0d.ack_res_held", v), res_q_o, vecs[v].res);
         check($sformatf("v%0d.ack_a_held", v), a_o, vecs[v].a);
      end

      // Switches changing every cycle.
      churn_press(3);
      check("churn.a", a_o, 6);
      churn_press(9);
      check("churn.b", b_o, 12);
      churn_press(6);
      check("churn.ctrl", ctrl_o, OP_SUB);
      check("churn.res", res_q_o, 4'd10);
      check("churn.car", car_q_o, 1);
      check("churn.of", of_q_o, 1);
      churn_press(1);
      check("churn.ack_state", state_o, S_A);
      check("churn.ack_a_held", a_o, 6);

      // Reset mid-entry with a press in flight.
      press_btn(4'd5, 3'd0);
      press_btn(4'd3, 3'd0);
      check("rst.pre_state", state_o, S_OP);
      check("rst.pre_a", a_o, 5);
      check("rst.pre_b", b_o, 3);
      @(negedge clk);
      btn = 1'b1;
      sw_op_i = OP_XOR;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      btn = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("rst_mid");
      press_n = 0;
      repeat (40) begin
         @(negedge clk);
         if (dut.u_deb.press_o) press_n++;
      end
      check("rst.discarded_presses", press_n, 0);
      check("rst.state_after", state_o, S_A);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
